// File: rtl/marquee_ctrl.sv
// Marquee controller: sequences an external 8-bit shift register through
// load / run / pause, pacing shifts with a prescaler and choosing the serial-fill bit.
module marquee_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       load_req,
    input  logic [1:0] mode,
    input  logic [7:0] q,
    output logic       sr_load,
    output logic       sr_shift,
    output logic       sr_sin,
    output logic [1:0] state,
    output logic [7:0] step_cnt
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        RUN   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic [PRE_W-1:0] pre;
    logic             stay_run;
    logic             shift_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt     = cur;
        sr_load = 1'b0;
        unique case (cur)
            IDLE: begin
                if (load_req || start) nxt = LOAD;
            end
            LOAD: begin
                sr_load = 1'b1;
                nxt     = RUN;
            end
            RUN: begin
                if (load_req)  nxt = LOAD;
                else if (stop) nxt = PAUSE;
            end
            PAUSE: begin
                if (load_req)   nxt = LOAD;
                else if (stop)  nxt = IDLE;
                else if (start) nxt = RUN;
            end
        endcase
    end

    // The prescaler only advances on RUN cycles that stay in RUN, so a stop
    // landing on terminal count keeps that count and resumes without losing a step.
    assign stay_run  = (cur == RUN) && !stop && !load_req;
    assign shift_nxt = stay_run && (pre == PRE_TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (cur == IDLE || cur == LOAD) begin
            pre <= '0;
        end else if (stay_run) begin
            pre <= shift_nxt ? '0 : pre + 1'b1;
        end
    end

    // Shift strobe is one cycle late; step_cnt advances as that shift completes,
    // so sr_sin for shift n is derived from step n.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_shift <= 1'b0;
            step_cnt <= 8'd0;
        end else begin
            sr_shift <= shift_nxt;
            if (cur == LOAD) begin
                step_cnt <= 8'd0;
            end else if (sr_shift) begin
                step_cnt <= step_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        sr_sin = 1'b0;
        unique case (mode)
            2'b00: sr_sin = q[0];
            2'b01: sr_sin = 1'b1;
            2'b10: sr_sin = 1'b0;
            2'b11: sr_sin = ~step_cnt[3];
        endcase
    end

    assign state = cur;

endmodule
